// File: rtl/part_deposit_pkg.sv
// Shared types and sizing helpers for the part_deposit_seq field-deposit engine.
package part_deposit_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  function automatic int idx_w(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int len_w(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  // A zero-length command still spends one WRITE cycle.
  function automatic int n_chunks(input int len, input int chunk);
    int n;
    n = (len + chunk - 1) / chunk;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/part_deposit_seq_if.sv
// Command/status bundle for part_deposit_seq; master = command issuer, slave = engine.
interface part_deposit_seq_if #(
  parameter int WIDTH      = 64,
  parameter int DATA_WIDTH = 16
);
  localparam int IDX_W = part_deposit_pkg::idx_w(WIDTH);
  localparam int LEN_W = part_deposit_pkg::len_w(DATA_WIDTH);

  // Handshake: a command transfers at a rising edge where in_valid & in_ready
  // and clear is low; the master holds all in_* fields stable while in_valid=1.
  logic                  in_valid;
  logic                  in_ready;
  logic [IDX_W-1:0]      in_start;
  logic [LEN_W-1:0]      in_len;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_or;
  logic                  clear;
  logic [WIDTH-1:0]      word;
  logic                  done;
  logic                  sticky;

  modport master (
    output in_valid, in_start, in_len, in_data, in_or, clear,
    input  in_ready, word, done, sticky
  );

  modport slave (
    input  in_valid, in_start, in_len, in_data, in_or, clear,
    output in_ready, word, done, sticky
  );

endinterface

// File: rtl/part_deposit_chunk.sv
// Places one CHUNK-bit slice of field data at an absolute word position.
// Overflow OR is only built when PART_DEPOSIT_STICKY_EN is defined.
module part_deposit_chunk #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 4,
  parameter int POS_W = 8,
  parameter int CNT_W = 3
) (
  input  logic [CHUNK-1:0] chunk_data_i,
  input  logic [CNT_W-1:0] valid_cnt_i,
  input  logic [POS_W-1:0] base_i,
  output logic [WIDTH-1:0] mask_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ovf_o
);
  localparam int AW = $clog2(WIDTH);

  always_comb begin
    logic [POS_W-1:0] pos;
    mask_o = '0;
    data_o = '0;
    ovf_o  = 1'b0;
    pos    = '0;
    for (int i = 0; i < CHUNK; i++) begin
      pos = base_i + POS_W'(i);
      if (CNT_W'(i) < valid_cnt_i) begin
        // Positions past the top of the word are dropped, never wrapped.
        if (pos < POS_W'(WIDTH)) begin
          mask_o[pos[AW-1:0]] = 1'b1;
          data_o[pos[AW-1:0]] = chunk_data_i[i];
        end
`ifdef PART_DEPOSIT_STICKY_EN
        else begin
          ovf_o = ovf_o | chunk_data_i[i];
        end
`endif
      end
    end
  end

endmodule

// File: rtl/part_deposit_seq.sv
// Sequential field-deposit engine: writes a field into a wide word CHUNK bits per cycle.
// Optional overflow sticky flag enabled by PART_DEPOSIT_STICKY_EN.
module part_deposit_seq
  import part_deposit_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DATA_WIDTH = 16,
  parameter int CHUNK      = 4
) (
  input  logic               clock,
  input  logic               resetn,
  part_deposit_seq_if.slave  bus,
  output state_e             dbg_state
);
  localparam int IDX_W = idx_w(WIDTH);
  localparam int LEN_W = len_w(DATA_WIDTH);
  localparam int NCH   = DATA_WIDTH / CHUNK;
  localparam int K_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int POS_W = IDX_W + 1;
  localparam int CNT_W = $clog2(CHUNK + 1);

  state_e                state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [IDX_W-1:0]      start_q, start_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  or_q, or_d;
  logic [WIDTH-1:0]      word_q, word_d;
  logic                  done_q, done_d;

  logic                  in_ready, accept, wr_en, last_chunk;
  logic [POS_W-1:0]      off, base, lenx, rem;
  logic [CNT_W-1:0]      vcnt;
  logic [CHUNK-1:0]      cdata;
  logic [WIDTH-1:0]      mask, adata;
  logic                  ovf;

  // Chunk k covers field bits [k*CHUNK +: CHUNK], truncated at the effective length.
  assign off        = POS_W'(k_q) * POS_W'(CHUNK);
  assign base       = POS_W'(start_q) + off;
  assign lenx       = POS_W'(len_q);
  assign rem        = (lenx > off) ? (lenx - off) : '0;
  assign vcnt       = (rem >= POS_W'(CHUNK)) ? CNT_W'(CHUNK) : CNT_W'(rem);
  assign cdata      = data_q[off +: CHUNK];
  assign last_chunk = (int'(k_q) == n_chunks(int'(len_q), CHUNK) - 1);

  part_deposit_chunk #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK),
    .POS_W (POS_W),
    .CNT_W (CNT_W)
  ) u_chunk (
    .chunk_data_i (cdata),
    .valid_cnt_i  (vcnt),
    .base_i       (base),
    .mask_o       (mask),
    .data_o       (adata),
    .ovf_o        (ovf)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.in_valid) state_d = WRITE;
        WRITE:   if (last_chunk)   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    accept   = in_ready && bus.in_valid && !bus.clear;
    wr_en    = (state_q == WRITE) && !bus.clear;
  end

  always_comb begin
    k_d     = k_q;
    start_d = start_q;
    len_d   = len_q;
    data_d  = data_q;
    or_d    = or_q;
    word_d  = word_q;
    done_d  = 1'b0;
    if (bus.clear) begin
      word_d = '0;
      k_d    = '0;
    end else if (accept) begin
      start_d = bus.in_start;
      len_d   = (bus.in_len > LEN_W'(DATA_WIDTH)) ? LEN_W'(DATA_WIDTH) : bus.in_len;
      data_d  = bus.in_data;
      or_d    = bus.in_or;
      k_d     = '0;
    end else if (wr_en) begin
      word_d = or_q ? (word_q | (mask & adata)) : ((word_q & ~mask) | (mask & adata));
      k_d    = k_q + K_W'(1);
      done_d = last_chunk;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      k_q     <= '0;
      start_q <= '0;
      len_q   <= '0;
      data_q  <= '0;
      or_q    <= 1'b0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      k_q     <= k_d;
      start_q <= start_d;
      len_q   <= len_d;
      data_q  <= data_d;
      or_q    <= or_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

`ifdef PART_DEPOSIT_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (bus.clear || accept) sticky_d = 1'b0;
    else if (wr_en)          sticky_d = sticky_q | ovf;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) sticky_q <= 1'b0;
    else         sticky_q <= sticky_d;
  end

  assign bus.sticky = sticky_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
  assign bus.sticky = 1'b0;
`endif

  assign bus.in_ready = in_ready;
  assign bus.word     = word_q;
  assign bus.done     = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_part_deposit_seq.sv
// Self-checking bench for part_deposit_seq: directed cases plus random commands vs. a bit-level model.
module tb_part_deposit_seq;
  import part_deposit_pkg::*;

  localparam int WIDTH = 64;
  localparam int DW    = 16;
  localparam int CHUNK = 4;
  localparam int W     = WIDTH + 1;

  logic   clock = 1'b0;
  logic   resetn = 1'b0;
  state_e dbg_state;

  part_deposit_seq_if #(.WIDTH(WIDTH), .DATA_WIDTH(DW)) bus ();

  part_deposit_seq #(.WIDTH(WIDTH), .DATA_WIDTH(DW), .CHUNK(CHUNK)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: {sticky, word} expected at each done pulse
  logic [W-1:0]     exp_q[$];
  logic [WIDTH-1:0] m_word;
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: walk the field bit by bit, no chunking.
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] w, input int start,
                                         input int len, input logic [DW-1:0] data,
                                         input bit orm);
    int   eff;
    logic s;
    eff = (len > DW) ? DW : len;
    s   = 1'b0;
    for (int i = 0; i < eff; i++) begin
      if (start + i < WIDTH) begin
        if (orm) w[start+i] = w[start+i] | data[i];
        else     w[start+i] = data[i];
      end else begin
        s = s | data[i];
      end
    end
`ifndef PART_DEPOSIT_STICKY_EN
    s = 1'b0;
`endif
    return {s, w};
  endfunction

  // monitor
  always @(negedge clock) begin
    if (resetn && bus.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending command");
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("done_word", W'(bus.word), W'(e[WIDTH-1:0]));
        check("done_sticky", W'(bus.sticky), W'(e[WIDTH]));
      end
    end
  end

  // driver tasks
  task automatic drive_cmd(input int start, input int len, input logic [DW-1:0] data, input bit orm);
    bus.in_valid = 1'b1;
    bus.in_start = 7'(start);
    bus.in_len   = 5'(len);
    bus.in_data  = data;
    bus.in_or    = orm;
  endtask

  task automatic do_cmd(input int start, input int len, input logic [DW-1:0] data, input bit orm);
    int           lat, busy, eff, n;
    logic [W-1:0] r;
    lat = 0;
    while (!bus.in_ready && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    drive_cmd(start, len, data, orm);
    r      = model(m_word, start, len, data, orm);
    m_word = r[WIDTH-1:0];
    exp_q.push_back(r);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    eff  = (len > DW) ? DW : len;
    n    = (eff == 0) ? 1 : (eff + CHUNK - 1) / CHUNK;
    lat  = 0;
    busy = 0;
    do begin
      @(negedge clock);
      lat++;
      if (!bus.in_ready) busy++;
    end while (!bus.done && lat < 50);
    check("done_latency", W'(lat), W'(n + 1));
    check("ready_low_cycles", W'(busy), W'(n));
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.in_start = '0;
    bus.in_len   = '0;
    bus.in_data  = '0;
    bus.in_or    = 1'b0;
    bus.clear    = 1'b0;
    m_word       = '0;

    // reset with in_valid held high
    @(negedge clock);
    check("rst_word", W'(bus.word), '0);
    check("rst_done", W'(bus.done), '0);
    check("rst_sticky", W'(bus.sticky), '0);
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", W'(bus.in_ready), W'(1));
      check("rst_state", W'(dbg_state), W'(IDLE));
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clock);

    do_cmd(8, 16, 16'hABCD, 1'b0);
    check("dir_abcd", W'(bus.word), W'(64'h0000_0000_00AB_CD00));
    do_cmd(60, 8, 16'h00F3, 1'b0);
    check("dir_top_nibble", W'(bus.word), W'(64'h3000_0000_00AB_CD00));
`ifdef PART_DEPOSIT_STICKY_EN
    check("dir_top_sticky", W'(bus.sticky), W'(1));
`else
    check("dir_top_sticky", W'(bus.sticky), W'(0));
`endif

    for (int i = 0; i < 4; i++) do_cmd(16 * i, 16, 16'hFFFF, 1'b0);
    do_cmd(16, 8, 16'h0000, 1'b1);
    check("or_zero_keeps", W'(bus.word), W'(64'hFFFF_FFFF_FFFF_FFFF));
    do_cmd(16, 8, 16'h0000, 1'b0);
    check("ovw_zero_byte", W'(bus.word), W'(64'hFFFF_FFFF_FF00_FFFF));

    do_cmd(4, 0, 16'hFFFF, 1'b0);
    do_cmd(64, 16, 16'hFFFF, 1'b0);
    do_cmd(0, 20, 16'h1234, 1'b0);
    check("len20_low16", W'(bus.word), W'(64'hFFFF_FFFF_FF00_1234));

    // clear after two chunk writes
    drive_cmd(0, 16, 16'h0000, 1'b0);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    bus.clear = 1'b1;
    @(posedge clock);
    #1 bus.clear = 1'b0;
    @(negedge clock);
    check("clr_word", W'(bus.word), '0);
    check("clr_done", W'(bus.done), '0);
    check("clr_ready", W'(bus.in_ready), W'(1));
    check("clr_sticky", W'(bus.sticky), '0);
    m_word = '0;
    repeat (6) @(negedge clock);

    // clear blocks a simultaneous command
    drive_cmd(0, 8, 16'h00FF, 1'b0);
    bus.clear = 1'b1;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    bus.clear = 1'b0;
    @(negedge clock);
    check("clr_blocks_accept", W'(dbg_state), W'(IDLE));
    repeat (6) @(negedge clock);
    check("clr_blocks_word", W'(bus.word), '0);

    do_cmd(20, 12, 16'h0ABC, 1'b0);

    for (int i = 0; i < 40; i++)
      do_cmd($urandom_range(0, 80), $urandom_range(0, 20), 16'($urandom), 1'($urandom_range(0, 1)));

    // asynchronous reset mid-command
    @(negedge clock);
    drive_cmd(0, 16, 16'hFFFF, 1'b0);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    check("arst_word", W'(bus.word), '0);
    check("arst_ready", W'(bus.in_ready), W'(1));
    check("arst_done", W'(bus.done), '0);
    m_word = '0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    do_cmd(32, 16, 16'h5A5A, 1'b1);

    repeat (3) @(negedge clock);
    check("queue_drained", W'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
